// File: rtl/poly_phase_scheduler.sv
// poly_phase_scheduler
// Sequencer for the polyphase filter: produces the coefficient phase select,
// the delay-line shift strobe (with zero-injection flag) and the output-valid
// strobe, locked to the upstream symbol strobe. Detects strobe misalignment
// and missing strobes, and flushes the delay line with zeros on disable.
//
// Optional feature: define POLY_SCHED_ERRCNT_EN to build the 8-bit saturating
// sync-error counter on o_err_count; otherwise o_err_count is tied to zero.

module poly_phase_scheduler #(
    parameter int unsigned NB_PHASES = 2,
    parameter int unsigned NB_FLUSH  = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_sample_valid,
    input  logic [NB_PHASES-1:0] i_phase_offset,
    output logic [NB_PHASES-1:0] o_phase,
    output logic                 o_shift_en,
    output logic                 o_zero_in,
    output logic                 o_out_valid,
    output logic                 o_busy,
    output logic                 o_sync_err,
    output logic [7:0]           o_err_count
);

    localparam int unsigned CW = (NB_FLUSH < 1) ? 1 : $clog2(NB_FLUSH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [NB_PHASES-1:0] off_q;
    logic [NB_PHASES-1:0] exp_w;
    logic [CW-1:0]        flush_cnt;
    logic                 at_exp;
    logic                 flush_done;

    logic [NB_PHASES-1:0] phase_nx;
    logic                 shift_nx;
    logic                 zero_nx;
    logic                 valid_nx;
    logic                 busy_nx;
    logic                 err_nx;

    // Strobe is expected on the phase just before the shift phase.
    assign exp_w      = off_q - 1'b1;
    assign at_exp     = (o_phase == exp_w);
    assign flush_done = (flush_cnt >= CW'(NB_FLUSH)) && at_exp;

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nx = ALIGN;
                end
            end
            ALIGN: begin
                if (!i_enable) begin
                    state_nx = IDLE;
                end else if (i_sample_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_nx = i_enable ? ALIGN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        phase_nx = '0;
        shift_nx = 1'b0;
        zero_nx  = 1'b0;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ALIGN: begin
                if (i_enable && i_sample_valid) begin
                    phase_nx = i_phase_offset;
                    shift_nx = 1'b1;
                    valid_nx = 1'b1;
                end
            end
            RUN: begin
                valid_nx = 1'b1;
                if (i_sample_valid && !at_exp) begin
                    // Misplaced strobe: restart rotation on the shift phase
                    err_nx   = 1'b1;
                    phase_nx = off_q;
                    shift_nx = 1'b1;
                end else begin
                    // Leaving exp always lands on off; missing strobe -> zero shift
                    phase_nx = o_phase + 1'b1;
                    shift_nx = at_exp;
                    zero_nx  = at_exp && !i_sample_valid;
                    err_nx   = at_exp && !i_sample_valid;
                end
            end
            FLUSH: begin
                if (!flush_done) begin
                    valid_nx = 1'b1;
                    phase_nx = o_phase + 1'b1;
                    shift_nx = at_exp;
                    zero_nx  = at_exp;
                end
            end
            default: begin
                phase_nx = '0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // Output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_phase     <= '0;
            o_shift_en  <= 1'b0;
            o_zero_in   <= 1'b0;
            o_out_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_sync_err  <= 1'b0;
        end else begin
            o_phase     <= phase_nx;
            o_shift_en  <= shift_nx;
            o_zero_in   <= zero_nx;
            o_out_valid <= valid_nx;
            o_busy      <= busy_nx;
            o_sync_err  <= err_nx;
        end
    end

    // Phase offset latched when the first symbol strobe leaves ALIGN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            off_q <= '0;
        end else if (state == ALIGN && i_enable && i_sample_valid) begin
            off_q <= i_phase_offset;
        end
    end

    // Counts zero shifts issued while flushing; cleared outside FLUSH
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            flush_cnt <= '0;
        end else if (state != FLUSH) begin
            flush_cnt <= '0;
        end else if (o_shift_en && o_zero_in && (flush_cnt < CW'(NB_FLUSH))) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

`ifdef POLY_SCHED_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating sync-error counter, cleared only by reset
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            err_cnt_q <= '0;
        end else if (err_nx && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign o_err_count = err_cnt_q;
`else
    assign o_err_count = '0;
`endif

endmodule
